// File: rtl/cordic_iter_engine.sv
// rtl/cordic_iter_engine.sv - iterative CORDIC engine, rotation and vectoring modes
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   in_valid / in_ready      operand handshake (in_ready high only in IDLE)
//   mode                     0 = rotation, 1 = vectoring, captured with operands
//   x_in, y_in, z_in         start vector and angle, signed Q2.(W-2)
//   out_valid / out_ready    result handshake
//   x_out, y_out, z_out      saturated result, Q2.(W-2), CORDIC gain not removed
//   busy                     high while RUN or DONE
module cordic_iter_engine #(
  parameter int W    = 16,
  parameter int ITER = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         mode,
  input  logic [W-1:0] x_in,
  input  logic [W-1:0] y_in,
  input  logic [W-1:0] z_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] x_out,
  output logic [W-1:0] y_out,
  output logic [W-1:0] z_out,
  output logic         busy
);

  localparam int WI = W + 2;          // two guard bits keep CORDIC growth from wrapping
  localparam int CW = $clog2(W + 1);  // iteration counter width
  localparam int F  = 56;             // fraction bits used while building the atan table

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t state, state_nx;

  logic signed [WI-1:0] x_r, y_r, z_r;
  logic signed [WI-1:0] x_nx, y_nx, z_nx;
  logic signed [WI-1:0] xs, ys, atan_cur;
  logic [CW-1:0]        iter;
  logic                 mode_r;
  logic                 d_pos;
  logic                 last;

  // atan(1/n) as a fixed-point power series with F fraction bits
  function automatic longint atan_series(input longint n);
    longint p;
    longint sum;
    p   = (longint'(1) << F) / n;
    sum = 0;
    for (int k = 0; k < 40; k++) begin
      if ((k % 2) == 0) sum = sum + p / longint'(2 * k + 1);
      else              sum = sum - p / longint'(2 * k + 1);
      p = p / (n * n);
    end
    return sum;
  endfunction

  // round(atan(2^-i) * 2^(W-2)); atan(1) via Machin's formula since its series converges slowly
  function automatic logic signed [WI-1:0] atan_entry(input int i);
    longint v;
    if (i == 0) v = 4 * atan_series(5) - atan_series(239);
    else        v = atan_series(longint'(1) << i);
    v = (v + (longint'(1) << (F - W + 1))) >>> (F - W + 2);
    return v[WI-1:0];
  endfunction

  function automatic logic [W-1:0] sat(input logic signed [WI-1:0] v);
    logic [2:0] top;
    top = v[WI-1:W-1];
    if ((&top) || !(|top)) return v[W-1:0];
    else if (v[WI-1])      return {1'b1, {(W-1){1'b0}}};
    else                   return {1'b0, {(W-1){1'b1}}};
  endfunction

  logic signed [WI-1:0] atan_tab [ITER];

  for (genvar g = 0; g < ITER; g++) begin : g_atan
    localparam logic signed [WI-1:0] ATAN_G = atan_entry(g);
    assign atan_tab[g] = ATAN_G;
  end

  // counter-indexed table read written as a compare mux so the index width stays free
  always_comb begin
    atan_cur = '0;
    for (int k = 0; k < ITER; k++) begin
      if (iter == CW'(k)) atan_cur = atan_tab[k];
    end
  end

  always_comb begin
    xs    = x_r >>> iter;
    ys    = y_r >>> iter;
    d_pos = mode_r ? y_r[WI-1] : ~z_r[WI-1];
    if (d_pos) begin
      x_nx = x_r - ys;
      y_nx = y_r + xs;
      z_nx = z_r - atan_cur;
    end else begin
      x_nx = x_r + ys;
      y_nx = y_r - xs;
      z_nx = z_r + atan_cur;
    end
  end

  assign last = (iter == CW'(ITER - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        if (last) state_nx = S_DONE;
      end
      S_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_r    <= '0;
      y_r    <= '0;
      z_r    <= '0;
      iter   <= '0;
      mode_r <= 1'b0;
      x_out  <= '0;
      y_out  <= '0;
      z_out  <= '0;
    end else begin
      if (state == S_IDLE && in_valid) begin
        x_r    <= {{2{x_in[W-1]}}, x_in};
        y_r    <= {{2{y_in[W-1]}}, y_in};
        z_r    <= {{2{z_in[W-1]}}, z_in};
        mode_r <= mode;
        iter   <= '0;
      end else if (state == S_RUN) begin
        x_r  <= x_nx;
        y_r  <= y_nx;
        z_r  <= z_nx;
        iter <= iter + CW'(1);
        // outputs move only on the edge that enters DONE
        if (last) begin
          x_out <= sat(x_nx);
          y_out <= sat(y_nx);
          z_out <= sat(z_nx);
        end
      end
    end
  end

endmodule

// File: tb/tb_cordic_iter_engine.sv
// tb/tb_cordic_iter_engine.sv - directed self-checking bench for cordic_iter_engine
module tb_cordic_iter_engine;

  localparam int W    = 16;
  localparam int ITER = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         mode = 1'b0;
  logic [W-1:0] x_in = '0;
  logic [W-1:0] y_in = '0;
  logic [W-1:0] z_in = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] x_out;
  logic [W-1:0] y_out;
  logic [W-1:0] z_out;
  logic         busy;

  int checks = 0;
  int errors = 0;

  cordic_iter_engine #(.W(W), .ITER(ITER)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .x_in      (x_in),
    .y_in      (y_in),
    .z_in      (z_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .x_out     (x_out),
    .y_out     (y_out),
    .z_out     (z_out),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp, input int tol = 0);
    checks++;
    if (got > exp + tol || got < exp - tol) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (tol %0d)", tag, got, exp, tol);
    end
  endtask

  function automatic int sx(input logic [W-1:0] v);
    return int'($signed(v));
  endfunction

  // present operands for one edge, then count edges until out_valid (bounded)
  task automatic run_op(input logic m, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic [W-1:0] z, output int lat);
    @(negedge clk);
    mode = m; x_in = x; y_in = y; z_in = z; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic release_result();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("idle_in_ready", int'(in_ready), 1);
    check("idle_busy", int'(busy), 0);
  endtask

  int lat;
  int sx0, sy0, sz0;

  initial begin
    // reset state
    #12;
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_x_out", sx(x_out), 0);
    @(negedge clk);
    rst = 1'b0;

    // rotation by +pi/6 with 1/K prescale
    run_op(1'b0, 16'h26DD, 16'h0000, 16'h2183, lat);
    check("rot_latency", lat, 16);
    check("rot_x", sx(x_out), 14189, 4);
    check("rot_y", sx(y_out), 8192, 4);
    check("rot_z", sx(z_out), 0, 4);

    // backpressure: DONE holds while inputs toggle
    sx0 = sx(x_out); sy0 = sx(y_out); sz0 = sx(z_out);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      in_valid = ~in_valid; mode = ~mode;
      x_in = W'($urandom); y_in = W'($urandom); z_in = W'($urandom);
      @(posedge clk); #1;
      check("bp_x", sx(x_out), sx0);
      check("bp_y", sx(y_out), sy0);
      check("bp_z", sx(z_out), sz0);
      check("bp_out_valid", int'(out_valid), 1);
      check("bp_in_ready", int'(in_ready), 0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    release_result();

    // rotation by -pi/6
    run_op(1'b0, 16'h26DD, 16'h0000, 16'hDE7D, lat);
    check("rotn_latency", lat, 16);
    check("rotn_x", sx(x_out), 14189, 4);
    check("rotn_y", sx(y_out), -8192, 4);
    check("rotn_z", sx(z_out), 0, 4);
    release_result();

    // vectoring of (0.5, 0.5)
    run_op(1'b1, 16'h2000, 16'h2000, 16'h0000, lat);
    check("vec_latency", lat, 16);
    check("vec_x", sx(x_out), 19078, 8);
    check("vec_y", sx(y_out), 0, 4);
    check("vec_z", sx(z_out), 12868, 4);
    release_result();

    // saturation
    run_op(1'b0, 16'h7FFF, 16'h7FFF, 16'h0000, lat);
    check("sat_latency", lat, 16);
    check("sat_x", sx(x_out), 32767);
    check("sat_y", sx(y_out), 32767);
    release_result();

    // reset at the 5th RUN edge; outputs still hold the saturated result beforehand
    @(negedge clk);
    mode = 1'b0; x_in = 16'h26DD; y_in = 16'h0000; z_in = 16'h2183; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_x", sx(x_out), 0);
    check("mid_rst_y", sx(y_out), 0);
    check("mid_rst_out_valid", int'(out_valid), 0);
    check("mid_rst_in_ready", int'(in_ready), 1);
    check("mid_rst_busy", int'(busy), 0);
    @(negedge clk);
    rst = 1'b0;
    run_op(1'b0, 16'h26DD, 16'h0000, 16'h2183, lat);
    check("post_rst_latency", lat, 16);
    check("post_rst_x", sx(x_out), 14189, 4);
    check("post_rst_y", sx(y_out), 8192, 4);
    release_result();

    // back-to-back with in_valid and out_ready high
    @(negedge clk);
    out_ready = 1'b1;
    mode = 1'b0; x_in = 16'h26DD; y_in = 16'h0000; z_in = 16'h2183; in_valid = 1'b1;
    @(posedge clk); #1;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check("b2b_a_latency", lat, 16);
    check("b2b_a_x", sx(x_out), 14189, 4);
    check("b2b_a_y", sx(y_out), 8192, 4);
    mode = 1'b1; x_in = 16'h2000; y_in = 16'h2000; z_in = 16'h0000;
    @(posedge clk); #1;
    check("b2b_hs_in_ready", int'(in_ready), 1);
    @(posedge clk); #1;
    check("b2b_accept_busy", int'(busy), 1);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check("b2b_b_latency", lat, 16);
    check("b2b_b_x", sx(x_out), 19078, 8);
    check("b2b_b_z", sx(z_out), 12868, 4);
    @(posedge clk); #1;
    check("b2b_end_in_ready", int'(in_ready), 1);
    out_ready = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cordic_iter_engine.md
CORDIC_ITER_ENGINE -- requirements
Module: cordic_iter_engine

Interface
REQ-001 Parameter W, default 16, meaning: data width of x/y/z, signed two's complement Q2.(W-2); legal range 8..24.
REQ-002 Parameter ITER, default 16, meaning: number of micro-rotations per operation; legal range 1..W.
REQ-003 Port clk, input, 1, meaning: single clock, all state updates on the rising edge.
REQ-004 Port rst, input, 1, meaning: asynchronous, active-high reset.
REQ-005 Port in_valid, input, 1, meaning: upstream operands present.
REQ-006 Port in_ready, output, 1, meaning: engine can accept operands.
REQ-007 Port mode, input, 1, meaning: 0 = rotation, 1 = vectoring; sampled with operands.
REQ-008 Port x_in / y_in / z_in, input, W each, meaning: start vector and angle in radians, Q2.(W-2).
REQ-009 Port out_valid, output, 1, meaning: result present.
REQ-010 Port out_ready, input, 1, meaning: downstream accepts result.
REQ-011 Port x_out / y_out / z_out, output, W each, meaning: result, Q2.(W-2), gain K≈1.64676 not compensated.
REQ-012 Port busy, output, 1, meaning: high in RUN or DONE.

Function
REQ-013 FSM states IDLE, RUN, DONE; in_ready SHALL be 1 only in IDLE.
REQ-014 Accept on in_valid && in_ready at edge t: latch x/y/z sign-extended to W+2 internal bits, latch mode, clear iteration counter i to 0, go to RUN.
REQ-015 Each RUN edge SHALL perform one micro-rotation with shift i, then increment i.
REQ-016 Direction d: rotation mode d=+1 if z>=0 else -1; vectoring mode d=+1 if y<0 else -1.
REQ-017 Update: x' = x - d*(y>>>i), y' = y + d*(x>>>i), z' = z - d*atan_i; arithmetic shifts, all in W+2 bits, no intermediate wrap.
REQ-018 atan_i SHALL be an internal constant table, round(atan(2^-i) * 2^(W-2)), entries 0..ITER-1, generated for any legal W/ITER.
REQ-019 On the edge completing i = ITER-1, go to DONE; out_valid SHALL rise exactly ITER edges after the accepting edge.
REQ-020 x_out/y_out/z_out SHALL saturate the internal values to [-2^(W-1), 2^(W-1)-1].
REQ-021 In DONE, outputs and out_valid SHALL hold stable until out_valid && out_ready; then go to IDLE, with in_ready=1 on the following cycle.
REQ-022 in_valid asserted in RUN/DONE SHALL be ignored (no capture); mode and operand changes outside acceptance SHALL have no effect.
REQ-023 Outputs SHALL not change while in RUN; they update only on entry to DONE.

Reset
REQ-024 rst asserted SHALL immediately force IDLE, i=0, out_valid=0, busy=0, x_out=y_out=z_out=0, in_ready=1 (in_ready low during rst permitted is NOT allowed; in_ready=1).
REQ-025 rst mid-RUN or mid-DONE SHALL abort the operation with no partial result ever presented.

Verification (W=16, ITER=16)
REQ-026 Rotation: x_in=0x26DD, y_in=0, z_in=0x2183 (pi/6) -> x_out=0x376D±4, y_out=0x2000±4, z_out=0±4, out_valid exactly 16 edges after accept.
REQ-027 Vectoring: x_in=0x2000, y_in=0x2000, z_in=0 -> z_out=0x3244±4, y_out=0±4, x_out=0x4A86±8.
REQ-028 Backpressure: hold out_ready=0 for 5 cycles in DONE while toggling in_valid/inputs -> outputs, out_valid=1, in_ready=0 unchanged; then out_ready=1 -> IDLE next cycle.
REQ-029 Reset mid-RUN: assert rst at 5th RUN edge -> outputs 0, out_valid=0, in_ready=1 asynchronously; new operation afterward completes correctly.
REQ-030 Saturation: rotation, x_in=y_in=0x7FFF, z_in=0 -> x_out=0x7FFF, y_out=0x7FFF (no wrap to negative).
REQ-031 Back-to-back: two operations with in_valid and out_ready tied high -> second accept occurs one cycle after first handshake, both results correct.
